// File: rtl/game_master_fsm_multi_shot.sv
// Game master for one target sprite and N_TORPEDOES torpedo sprites.
// Limits launches per round, keeps a saturating win score, and hands off to the end-of-game timer.
module game_master_fsm_multi_shot #(
  parameter int N_TORPEDOES     = 2,
  parameter int SHOTS_PER_ROUND = 3,
  parameter int SCORE_W         = 4,
  parameter int SHOT_W          = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_target_enable_update,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_xy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_dxy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_enable_update,
  input  logic                   sprite_target_within_screen,
  input  logic [N_TORPEDOES-1:0] sprite_torpedo_within_screen,
  input  logic [N_TORPEDOES-1:0] collision,
  output logic                   end_of_game_timer_start,
  input  logic                   end_of_game_timer_running,
  output logic                   game_won,
  output logic [SHOT_W-1:0]      shots_left,
  output logic [SCORE_W-1:0]     score
);

  typedef enum logic [2:0] {
    START = 3'b001,
    PLAY  = 3'b010,
    END   = 3'b100
  } state_t;

  state_t state, state_next;

  logic                   key_q;
  logic                   launch_req;
  logic [N_TORPEDOES-1:0] active, active_next;
  logic [N_TORPEDOES-1:0] free, sel_oh;
  logic                   hit;
  logic                   end_wait, end_wait_next;

  logic                   tgt_wxy_next, tgt_wdxy_next, tgt_en_next;
  logic [N_TORPEDOES-1:0] torp_wxy_next, torp_wdxy_next, torp_en_next;
  logic                   timer_start_next, game_won_next;
  logic [SHOT_W-1:0]      shots_next;
  logic [SCORE_W-1:0]     score_next;

  assign launch_req = key & ~key_q;
  assign hit        = |(collision & active);
  assign free       = ~active;
  // Isolate the lowest free torpedo as a one-hot mask.
  assign sel_oh     = free & (~free + 1'b1);

  always_comb begin
    state_next       = state;
    active_next      = active;
    end_wait_next    = 1'b0;
    tgt_wxy_next     = 1'b0;
    tgt_wdxy_next    = 1'b0;
    tgt_en_next      = 1'b0;
    torp_wxy_next    = '0;
    torp_wdxy_next   = '0;
    torp_en_next     = '0;
    timer_start_next = 1'b0;
    game_won_next    = game_won;
    shots_next       = shots_left;
    score_next       = score;

    case (state)
      START: begin
        tgt_wxy_next  = 1'b1;
        tgt_wdxy_next = 1'b1;
        torp_wxy_next = '1;
        game_won_next = 1'b0;
        shots_next    = SHOT_W'(SHOTS_PER_ROUND);
        active_next   = '0;
        state_next    = PLAY;
      end
      PLAY: begin
        active_next = active & sprite_torpedo_within_screen;
        if (hit) begin
          game_won_next    = 1'b1;
          if (score != '1) score_next = score + 1'b1;
          timer_start_next = 1'b1;
          state_next       = END;
        end else if (!sprite_target_within_screen) begin
          timer_start_next = 1'b1;
          state_next       = END;
        end else if (shots_left == '0 && active == '0) begin
          timer_start_next = 1'b1;
          state_next       = END;
        end else begin
          // Requests with no free torpedo or no shots left are simply dropped.
          if (launch_req && shots_left != '0 && free != '0) begin
            torp_wxy_next  = sel_oh;
            torp_wdxy_next = sel_oh;
            active_next    = active_next | sel_oh;
            shots_next     = shots_left - 1'b1;
          end
          tgt_en_next  = 1'b1;
          torp_en_next = active_next;
        end
      end
      END: begin
        end_wait_next = 1'b1;
        if (end_wait && !end_of_game_timer_running) begin
          state_next  = START;
          active_next = '0;
        end
      end
      default: begin
        state_next  = START;
        active_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                        <= START;
      key_q                        <= 1'b0;
      active                       <= '0;
      end_wait                     <= 1'b0;
      sprite_target_write_xy       <= 1'b0;
      sprite_target_write_dxy      <= 1'b0;
      sprite_target_enable_update  <= 1'b0;
      sprite_torpedo_write_xy      <= '0;
      sprite_torpedo_write_dxy     <= '0;
      sprite_torpedo_enable_update <= '0;
      end_of_game_timer_start      <= 1'b0;
      game_won                     <= 1'b0;
      shots_left                   <= '0;
      score                        <= '0;
    end else begin
      state                        <= state_next;
      key_q                        <= key;
      active                       <= active_next;
      end_wait                     <= end_wait_next;
      sprite_target_write_xy       <= tgt_wxy_next;
      sprite_target_write_dxy      <= tgt_wdxy_next;
      sprite_target_enable_update  <= tgt_en_next;
      sprite_torpedo_write_xy      <= torp_wxy_next;
      sprite_torpedo_write_dxy     <= torp_wdxy_next;
      sprite_torpedo_enable_update <= torp_en_next;
      end_of_game_timer_start      <= timer_start_next;
      game_won                     <= game_won_next;
      shots_left                   <= shots_next;
      score                        <= score_next;
    end
  end

endmodule

// File: tb/tb_game_master_fsm_multi_shot.sv
// Bench for game_master_fsm_multi_shot: directed scenarios plus random play,
// all checked against a round/torpedo-level reference model.
module tb_game_master_fsm_multi_shot;

  localparam int N         = 2;
  localparam int SHOTS     = 3;
  localparam int SCORE_W   = 2;
  localparam int SHOT_W    = 4;
  localparam int SCORE_MAX = 3;
  localparam int P_START = 0, P_PLAY = 1, P_END = 2;

  logic           clk = 1'b0;
  logic           reset, key, tgt_within, timer_running;
  logic [N-1:0]   torp_within, collision;
  logic           tgt_wxy, tgt_wdxy, tgt_en, timer_start, won;
  logic [N-1:0]   torp_wxy, torp_wdxy, torp_en;
  logic [SHOT_W-1:0]  shots;
  logic [SCORE_W-1:0] score;

  int checks = 0;
  int errors = 0;

  // Reference model: round phase, flying torpedoes, shot and score tallies.
  int     m_phase, m_end_age, m_shots, m_score;
  bit     m_won, m_key_prev;
  bit [N-1:0] m_flying;
  bit     e_tgt_wxy, e_tgt_wdxy, e_tgt_en, e_timer_start;
  bit [N-1:0] e_torp_wxy, e_torp_wdxy, e_torp_en;

  logic [16:0] out_vec, exp_vec;
  assign out_vec = {tgt_wxy, tgt_wdxy, tgt_en, torp_wxy, torp_wdxy, torp_en,
                    timer_start, won, shots, score};
  assign exp_vec = {e_tgt_wxy, e_tgt_wdxy, e_tgt_en, e_torp_wxy, e_torp_wdxy, e_torp_en,
                    e_timer_start, m_won, SHOT_W'(m_shots), SCORE_W'(m_score)};

  game_master_fsm_multi_shot #(
    .N_TORPEDOES(N), .SHOTS_PER_ROUND(SHOTS), .SCORE_W(SCORE_W), .SHOT_W(SHOT_W)
  ) dut (
    .clk(clk), .reset(reset), .key(key),
    .sprite_target_write_xy(tgt_wxy),
    .sprite_target_write_dxy(tgt_wdxy),
    .sprite_target_enable_update(tgt_en),
    .sprite_torpedo_write_xy(torp_wxy),
    .sprite_torpedo_write_dxy(torp_wdxy),
    .sprite_torpedo_enable_update(torp_en),
    .sprite_target_within_screen(tgt_within),
    .sprite_torpedo_within_screen(torp_within),
    .collision(collision),
    .end_of_game_timer_start(timer_start),
    .end_of_game_timer_running(timer_running),
    .game_won(won), .shots_left(shots), .score(score)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int  first_free;
    bit  any_flying, hit, press;
    e_tgt_wxy = 0; e_tgt_wdxy = 0; e_tgt_en = 0; e_timer_start = 0;
    e_torp_wxy = '0; e_torp_wdxy = '0; e_torp_en = '0;
    if (reset) begin
      m_phase = P_START; m_end_age = 0; m_shots = 0; m_score = 0;
      m_won = 0; m_key_prev = 0; m_flying = '0;
    end else begin
      press = key && !m_key_prev;
      m_key_prev = key;
      if (m_phase == P_START) begin
        e_tgt_wxy = 1; e_tgt_wdxy = 1; e_torp_wxy = '1;
        m_won = 0; m_shots = SHOTS; m_flying = '0;
        m_phase = P_PLAY;
      end else if (m_phase == P_PLAY) begin
        first_free = -1; any_flying = 0; hit = 0;
        for (int i = N - 1; i >= 0; i--) if (!m_flying[i]) first_free = i;
        for (int i = 0; i < N; i++) begin
          if (m_flying[i]) any_flying = 1;
          if (m_flying[i] && collision[i]) hit = 1;
        end
        for (int i = 0; i < N; i++) if (m_flying[i] && !torp_within[i]) m_flying[i] = 0;
        if (hit || !tgt_within || (m_shots == 0 && !any_flying)) begin
          if (hit) begin
            m_won = 1;
            if (m_score < SCORE_MAX) m_score++;
          end
          e_timer_start = 1;
          m_phase = P_END;
          m_end_age = 0;
        end else begin
          if (press && m_shots > 0 && first_free >= 0) begin
            e_torp_wxy[first_free] = 1;
            e_torp_wdxy[first_free] = 1;
            m_flying[first_free] = 1;
            m_shots--;
          end
          e_tgt_en = 1;
          e_torp_en = m_flying;
        end
      end else begin
        m_end_age++;
        if (m_end_age >= 2 && !timer_running) begin
          m_phase = P_START;
          m_flying = '0;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; key = 0; tgt_within = 1; timer_running = 0; torp_within = '1; collision = '0;
    cycle(); cycle();
    checks++;
    if (out_vec !== 17'd0) begin errors++; $display("[TB] FAIL reset_outputs got %h want 0", out_vec); end
    reset = 0;
    cycle();
    checks++;
    if ({tgt_wxy, tgt_wdxy, torp_wxy} !== 4'b1111) begin
      errors++; $display("[TB] FAIL start_pulses got %b want 1111", {tgt_wxy, tgt_wdxy, torp_wxy});
    end
    cycle();
    checks++;
    if (shots !== 4'd3 || tgt_en !== 1'b1 || tgt_wxy !== 1'b0) begin
      errors++; $display("[TB] FAIL play_entry got shots=%0d en=%b wxy=%b want 3 1 0", shots, tgt_en, tgt_wxy);
    end
  endtask

  task automatic test_launches();
    logic [N-1:0] want [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin torp_within = 2'b10; cycle(); torp_within = 2'b11; end
      key = 1; cycle();
      checks++;
      if (torp_wdxy !== want[k] || out_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL launch_%0d got wdxy=%b vec=%h want %b vec=%h", k, torp_wdxy, out_vec, want[k], exp_vec);
      end
      if (k == 2) begin
        checks++;
        if (shots !== 4'd1) begin errors++; $display("[TB] FAIL dropped_launch got shots=%0d want 1", shots); end
      end
      key = 0; cycle();
    end
    checks++;
    if (shots !== 4'd0) begin errors++; $display("[TB] FAIL last_shot got shots=%0d want 0", shots); end
  endtask

  task automatic test_hit();
    bit found = 0;
    collision = 2'b10; cycle(); collision = '0;
    checks++;
    if (won !== 1'b1 || score !== 2'd1 || timer_start !== 1'b1) begin
      errors++; $display("[TB] FAIL hit got won=%b score=%0d ts=%b want 1 1 1", won, score, timer_start);
    end
    timer_running = 1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (timer_start !== 1'b0 || won !== 1'b1 || tgt_en !== 1'b0 || out_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL end_hold got vec=%h want %h", out_vec, exp_vec);
      end
    end
    timer_running = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (tgt_wxy === 1'b1) found = 1;
    end
    checks++;
    if (!found || won !== 1'b0) begin errors++; $display("[TB] FAIL restart_after_win got found=%b won=%b want 1 0", found, won); end
  endtask

  task automatic test_miss();
    bit found = 0;
    collision = 2'b01; cycle(); collision = '0;
    checks++;
    if (won !== 1'b0 || timer_start !== 1'b0 || tgt_en !== 1'b1) begin
      errors++; $display("[TB] FAIL inactive_collision got won=%b ts=%b en=%b want 0 0 1", won, timer_start, tgt_en);
    end
    tgt_within = 0; cycle(); tgt_within = 1;
    checks++;
    if (won !== 1'b0 || timer_start !== 1'b1 || score !== 2'd1 || tgt_en !== 1'b0) begin
      errors++; $display("[TB] FAIL target_lost got won=%b ts=%b score=%0d want 0 1 1", won, timer_start, score);
    end
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (tgt_wxy === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL restart_after_miss got no start pulse want one"); end
  endtask

  task automatic test_out_of_shots();
    bit found = 0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      key = 1; cycle();
      checks++;
      if (torp_wdxy !== 2'b01) begin errors++; $display("[TB] FAIL shot_%0d got wdxy=%b want 01", k, torp_wdxy); end
      key = 0; torp_within = 2'b00; cycle(); torp_within = 2'b11;
    end
    for (int k = 0; k < 5 && !found; k++) begin
      if (timer_start === 1'b1) found = 1; else cycle();
    end
    checks++;
    if (!found || shots !== 4'd0 || won !== 1'b0) begin
      errors++; $display("[TB] FAIL out_of_shots got found=%b shots=%0d won=%b want 1 0 0", found, shots, won);
    end
    reset = 1; key = 1; cycle(); cycle(); reset = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (torp_wdxy !== 2'b00 || out_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL held_key_%0d got wdxy=%b want 00", k, torp_wdxy);
      end
    end
    key = 0; cycle(); key = 1; cycle();
    checks++;
    if (torp_wdxy !== 2'b01 || shots !== 4'd2) begin
      errors++; $display("[TB] FAIL repress got wdxy=%b shots=%0d want 01 2", torp_wdxy, shots);
    end
    key = 0;
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 5; r++) begin
      bit found = 0;
      key = 0; cycle(); key = 1; cycle(); key = 0; cycle();
      collision = 2'b11; cycle(); collision = '0;
      checks++;
      if (timer_start !== 1'b1 || won !== 1'b1 || out_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL round_%0d_win got vec=%h want %h", r, out_vec, exp_vec);
      end
      for (int k = 0; k < 10 && !found; k++) begin
        cycle();
        if (tgt_wxy === 1'b1) found = 1;
      end
      cycle();
    end
    checks++;
    if (score !== 2'd3) begin errors++; $display("[TB] FAIL score_saturate got %0d want 3", score); end
    key = 1; cycle(); reset = 1; cycle(); reset = 0; key = 0;
    checks++;
    if (out_vec !== 17'd0) begin errors++; $display("[TB] FAIL reset_in_play got %h want 0", out_vec); end
  endtask

  task automatic test_random();
    bit prev_ts = 0;
    reset = 1; cycle(); reset = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) key = ~key;
      tgt_within = ($urandom_range(0, 40) != 0);
      for (int i = 0; i < N; i++) begin
        torp_within[i] = ($urandom_range(0, 5) != 0);
        collision[i]   = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 3) == 0) timer_running = $urandom_range(0, 1);
      if ($urandom_range(0, 999) == 0) reset = 1; else reset = 0;
      cycle();
      checks++;
      if (out_vec !== exp_vec || (prev_ts && timer_start)) begin
        errors++; $display("[TB] FAIL random_%0d got %h want %h", k, out_vec, exp_vec);
      end
      prev_ts = timer_start;
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; key = 0; tgt_within = 1; timer_running = 0; torp_within = '1; collision = '0;
    test_reset();
    test_launches();
    test_hit();
    test_miss();
    test_out_of_shots();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
